// File: rtl/pipeline_stall_flush_regs.sv
// -----------------------------------------------------------------------------
// pipeline_stall_flush_regs
//
// Purpose
//   Front-end pipeline registers driven by the hazard-detection unit: the fetch
//   PC, the IF/ID register and the ID/EX control register. The hazard controls
//   (pc_write, if_id_write, if_flush, ctrl_mux_sel) and the EX-stage branch
//   redirect are applied here in the cycle they are presented. Bubbles and
//   wrong-path flushes are inserted here. Saturating counters record how often
//   each action happened. A watchdog flags a stall that never ends.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_write            1 = advance PC, 0 = hold (load-use stall)
//   if_id_write         1 = IF/ID captures the fetch, 0 = hold
//   if_flush            1 = clear IF/ID to a bubble
//   ctrl_mux_sel        1 = inject zero control into ID/EX (bubble)
//   redirect_valid/_pc  taken branch resolved in EX and its target
//   instr_in            instruction fetched at pc
//   ctrl_in             decoded control bundle for if_id_instr
//   cnt_clr             synchronous clear of counters and watchdog
//   pc                  current fetch PC
//   if_id_pc/_instr/_valid   IF/ID contents
//   id_ex_pc/_ctrl/_valid    ID/EX contents
//   stall/flush/bubble_count saturating event counters
//   stall_timeout       sticky: a stall run exceeded STALL_MAX cycles
// -----------------------------------------------------------------------------
module pipeline_stall_flush_regs #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               CTRL_W    = 8,
    parameter int               CNT_W     = 16,
    parameter int               STALL_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              if_flush,
    input  logic              ctrl_mux_sel,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic [31:0]       instr_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              cnt_clr,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  bubble_count,
    output logic              stall_timeout
);

    // addi x0, x0, 0 -- canonical RISC-V NOP used to fill a flushed IF/ID
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Run counter must be able to hold STALL_MAX+1, where it saturates.
    localparam int               RUN_W     = $clog2(STALL_MAX + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_MAX + 1);

    localparam int NUM_CNT = 3;

    // -------------------------------------------------------------------------
    // Derived hazard conditions
    // -------------------------------------------------------------------------
    logic flush;
    logic eff_stall;

    // A resolved taken branch always kills the younger instruction in IF/ID.
    assign flush     = if_flush | redirect_valid;
    // A redirect moves the PC even when the hazard unit asked to hold it, so
    // that cycle is not counted as a stall.
    assign eff_stall = ~pc_write & ~redirect_valid;

    // -------------------------------------------------------------------------
    // PC register
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (pc_write) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID register
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        // Flush beats a hold: a wrong-path instruction must not survive a stall.
        if (flush) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (if_id_write) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = instr_in;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // ID/EX control register -- never stalls; either a real instruction or a
    // fully zeroed bubble moves forward every cycle.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]   id_ex_pc_q,    id_ex_pc_d;
    logic [CTRL_W-1:0] id_ex_ctrl_q,  id_ex_ctrl_d;
    logic              id_ex_valid_q, id_ex_valid_d;

    always_comb begin
        id_ex_pc_d    = '0;
        id_ex_ctrl_d  = '0;
        id_ex_valid_d = 1'b0;
        if (!ctrl_mux_sel && if_id_valid_q) begin
            id_ex_pc_d    = if_id_pc_q;
            id_ex_ctrl_d  = ctrl_in;
            id_ex_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_pc_q    <= '0;
            id_ex_ctrl_q  <= '0;
            id_ex_valid_q <= 1'b0;
        end else begin
            id_ex_pc_q    <= id_ex_pc_d;
            id_ex_ctrl_q  <= id_ex_ctrl_d;
            id_ex_valid_q <= id_ex_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating event counters: index 0 stall, 1 flush, 2 bubble
    // -------------------------------------------------------------------------
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    assign cnt_inc = {ctrl_mux_sel, flush, eff_stall};

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stall watchdog
    // -------------------------------------------------------------------------
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        run_d = '0;
        if (!cnt_clr && eff_stall) begin
            run_d = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Timeout is raised on the same edge the run reaches its limit, so it is
    // visible right after the (STALL_MAX+1)-th consecutive stall cycle.
    always_comb begin
        timeout_d = timeout_q | (run_d == RUN_LIMIT);
        if (cnt_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs -- all straight from registers
    // -------------------------------------------------------------------------
    assign pc            = pc_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_valid   = if_id_valid_q;
    assign id_ex_pc      = id_ex_pc_q;
    assign id_ex_ctrl    = id_ex_ctrl_q;
    assign id_ex_valid   = id_ex_valid_q;
    assign stall_count   = cnt_val[0];
    assign flush_count   = cnt_val[1];
    assign bubble_count  = cnt_val[2];
    assign stall_timeout = timeout_q;

endmodule
